rsp_s2_prep_dcest_ctrl: RTL



---
 rtl/rsp_s2_prep_dcest_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/rsp_s2_prep_dcest_ctrl.sv
// Stage-2 prep DC-estimation sequencer: streams the sample RAM into the DC
// estimator in chirp-major order, then captures the estimate after the pipeline latency.
module rsp_s2_prep_dcest_ctrl #(
    parameter int READ_RAM_WIDTH = 128,
    parameter int ADDR_WIDTH     = 12,
    parameter int RAM_RD_LAT     = 2,
    parameter int RESULT_LAT     = 14
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_start,
    input  logic                      i_abort,
    input  logic                      i_hold,
    input  logic [ADDR_WIDTH-1:0]     i_base_addr,
    input  logic [ADDR_WIDTH-1:0]     i_chirp_stride,
    input  logic [12:0]               DCEST_SMP_CNT,
    input  logic [9:0]                DCEST_CHP_CNT,
    input  logic [3:0]                DCEST_FRM_CNT,
    input  logic                      i_is_real,
    output logic                      ram_rd_en,
    output logic [ADDR_WIDTH-1:0]     ram_rd_addr,
    input  logic [READ_RAM_WIDTH-1:0] ram_rd_data,
    output logic [READ_RAM_WIDTH-1:0] est_x0_data,
    output logic                      est_x0_valid,
    output logic                      est_x0_last,
    input  logic [31:0]               est_y0,
    output logic [31:0]               o_dc_result,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_cfg_err,
    output logic [2:0]                dbg_state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CHECK    = 3'd1,
        READ     = 3'd2,
        DRAIN    = 3'd3,
        WAIT_RES = 3'd4,
        DONE     = 3'd5
    } state_t;

    localparam logic [5:0] RES_LAST = 6'(RESULT_LAT - 1);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [ADDR_WIDTH-1:0]   stride_q;
    logic [12:0]             smp_q;
    logic [9:0]              chp_q;
    logic [3:0]              frm_q;
    logic                    real_q;
    logic [10:0]             word_max;
    logic [10:0]             word_cnt;
    logic [9:0]              chirp_cnt;
    logic [3:0]              frame_cnt;
    logic [ADDR_WIDTH-1:0]   chirp_base;
    logic [5:0]              wait_cnt;
    logic [RAM_RD_LAT-1:0]   dl_valid;
    logic [RAM_RD_LAT-1:0]   dl_last;

    logic [13:0] smp_p1;
    logic [11:0] wpc;
    logic        cfg_bad;
    logic        final_word;

    assign smp_p1     = {1'b0, smp_q} + 14'd1;
    assign wpc        = real_q ? 12'(smp_p1 >> 3) : 12'(smp_p1 >> 2);
    assign cfg_bad    = (real_q ? (smp_p1[2:0] != 3'd0) : (smp_p1[1:0] != 2'd0)) || (wpc == 12'd0);
    assign final_word = (word_cnt == word_max) && (chirp_cnt == chp_q) && (frame_cnt == frm_q);

    // Estimator stream has no backpressure: a beat is transferred on every
    // cycle est_x0_valid is high, and est_x0_last only ever rides on such a beat.
    assign ram_rd_en    = (state == READ) && !i_hold && !i_abort;
    assign ram_rd_addr  = chirp_base + ADDR_WIDTH'(word_cnt);
    assign est_x0_valid = dl_valid[RAM_RD_LAT-1];
    assign est_x0_last  = dl_last[RAM_RD_LAT-1];
    assign est_x0_data  = est_x0_valid ? ram_rd_data : '0;
    assign o_busy       = (state != IDLE);
    assign o_done       = (state == DONE);
    assign dbg_state    = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            base_q      <= '0;
            stride_q    <= '0;
            smp_q       <= '0;
            chp_q       <= '0;
            frm_q       <= '0;
            real_q      <= 1'b0;
            word_max    <= '0;
            word_cnt    <= '0;
            chirp_cnt   <= '0;
            frame_cnt   <= '0;
            chirp_base  <= '0;
            wait_cnt    <= '0;
            dl_valid    <= '0;
            dl_last     <= '0;
            o_dc_result <= '0;
            o_cfg_err   <= 1'b0;
        end else begin
            for (int i = RAM_RD_LAT - 1; i > 0; i--) begin
                dl_valid[i] <= dl_valid[i-1];
                dl_last[i]  <= dl_last[i-1];
            end
            dl_valid[0] <= ram_rd_en;
            dl_last[0]  <= ram_rd_en & final_word;

            if (i_abort && state != IDLE) begin
                state    <= IDLE;
                dl_valid <= '0;
                dl_last  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (i_start) begin
                            base_q     <= i_base_addr;
                            stride_q   <= i_chirp_stride;
                            smp_q      <= DCEST_SMP_CNT;
                            chp_q      <= DCEST_CHP_CNT;
                            frm_q      <= DCEST_FRM_CNT;
                            real_q     <= i_is_real;
                            chirp_base <= i_base_addr;
                            word_cnt   <= '0;
                            chirp_cnt  <= '0;
                            frame_cnt  <= '0;
                            o_cfg_err  <= 1'b0;
                            state      <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (cfg_bad) begin
                            o_cfg_err <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            word_max <= 11'(wpc - 12'd1);
                            state    <= READ;
                        end
                    end
                    READ: begin
                        if (!i_hold) begin
                            if (final_word) begin
                                state <= DRAIN;
                            end else if (word_cnt == word_max) begin
                                // chirp_base tracks base + global_chirp * stride incrementally
                                word_cnt   <= '0;
                                chirp_base <= chirp_base + stride_q;
                                if (chirp_cnt == chp_q) begin
                                    chirp_cnt <= '0;
                                    frame_cnt <= frame_cnt + 4'd1;
                                end else begin
                                    chirp_cnt <= chirp_cnt + 10'd1;
                                end
                            end else begin
                                word_cnt <= word_cnt + 11'd1;
                            end
                        end
                    end
                    DRAIN: begin
                        if (dl_last[RAM_RD_LAT-1]) begin
                            if (RESULT_LAT == 1) begin
                                o_dc_result <= est_y0;
                                state       <= DONE;
                            end else begin
                                wait_cnt <= 6'd1;
                                state    <= WAIT_RES;
                            end
                        end
                    end
                    WAIT_RES: begin
                        // wait_cnt = cycles elapsed since the last beat left the delay line
                        if (wait_cnt == RES_LAST) begin
                            o_dc_result <= est_y0;
                            state       <= DONE;
                        end else begin
                            wait_cnt <= wait_cnt + 6'd1;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
